// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serializer.
// Ports: clk, rst_n (sync, active-low), wr_en/wr_data/wr_ready write side,
//        busy, level (FIFO occupancy), uart_tx (serial line, idle high).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0]   LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  logic w_has;
  logic w_bit_end;
  logic w_push;
  logic w_pop;

  assign w_has     = (r_level != '0);
  assign w_bit_end = (r_cnt == LAST);
  // Only the registered level gates writes, so a same-cycle pop
  // never frees a slot for a write to a full FIFO.
  assign wr_ready  = (r_level != FULL);
  assign w_push    = wr_en && wr_ready;
  assign w_pop     = w_has &&
                     ((r_state == IDLE) ||
                      ((r_state == STOP) && w_bit_end));

  assign level   = r_level;
  assign busy    = r_busy;
  assign uart_tx = r_tx;

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // The line is a registered image of the previous cycle's state,
  // so it trails the state machine by one clock and never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_tx   <= (r_state == START) ? 1'b0 :
                (r_state == DATA)  ? r_shift[0] : 1'b1;
      r_busy <= (r_state != IDLE) || w_has;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Instance u4 uses CLKS_PER_BIT=4, u1 uses CLKS_PER_BIT=1.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic [2:0] level;
  logic       tx;
  logic       wr_en1;
  logic [7:0] wr_data1;
  logic       wr_ready1;
  logic       busy1;
  logic [2:0] level1;
  logic       tx1;

  int n_checks = 0;
  int n_fail   = 0;
  int maxlvl   = 0;
  bit cap      = 0;
  logic       q[$];
  logic [7:0] expq[$];

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy),
    .level(level), .uart_tx(tx)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en1), .wr_data(wr_data1),
    .wr_ready(wr_ready1), .busy(busy1),
    .level(level1), .uart_tx(tx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cap) q.push_back(tx);
    if (int'(level) > maxlvl) maxlvl = int'(level);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    check("drain_busy", busy, 0);
    repeat (8) tick();
  endtask

  // Frames are 40 samples at 4 clocks/bit; consecutive frames
  // must start exactly 40 samples apart (no idle gap).
  task automatic decode(input string tag);
    int i;
    int zeros;
    logic [7:0] b;
    bit ok;
    i  = 0;
    ok = 1;
    while (i < q.size() && q[i] != 1'b0) i++;
    foreach (expq[k]) begin
      if (ok) begin
        check({tag, "_avail"}, (i + 40 <= q.size()), 1);
        if (i + 40 > q.size()) begin
          ok = 0;
        end else begin
          check({tag, "_start"}, q[i+1], 0);
          for (int j = 0; j < 8; j++) b[j] = q[i+6+4*j];
          check({tag, "_byte"}, b, expq[k]);
          check({tag, "_stop"}, q[i+38], 1);
          i += 40;
        end
      end
    end
    zeros = 0;
    for (int j = i; j < q.size(); j++) if (q[j] == 1'b0) zeros++;
    check({tag, "_tail_idle"}, zeros, 0);
  endtask

  initial begin
    int e;
    int n;
    int zeros;
    logic [7:0] b;
    logic [19:0] pat;

    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    wr_en1   = 1'b0;
    wr_data1 = 8'h00;
    tick();
    tick();
    check("rst_tx", tx, 1);
    check("rst_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_tx1", tx1, 1);
    check("rst_level1", level1, 0);
    rst_n = 1'b1;
    tick();

    // single byte 0x55
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    check("t1_level_n", level, 1);
    for (int k = 1; k <= 42; k++) begin
      tick();
      if (k == 1) begin
        check("t1_level_pop", level, 0);
        check("t1_pre_tx", tx, 1);
      end
      if (k >= 2 && k <= 41)
        check("t1_bit", tx, exp_bit(8'h55, (k - 2) / 4));
      if (k == 41) check("t1_busy_hold", busy, 1);
      if (k == 42) begin
        check("t1_busy_low", busy, 0);
        check("t1_tx_idle", tx, 1);
      end
    end

    // burst of 16 bytes, writes only while wr_ready
    repeat (3) tick();
    q.delete();
    expq.delete();
    maxlvl = 0;
    cap    = 1;
    for (int k = 0; k < 16; k++) begin
      b = 8'(k * 17);
      expq.push_back(b);
      n = 0;
      while (!wr_ready && n < 500) begin
        tick();
        n++;
      end
      check("t2_ready_wait", wr_ready, 1);
      wr_en   = 1'b1;
      wr_data = b;
      tick();
      wr_en = 1'b0;
    end
    drain();
    cap = 0;
    decode("t2");
    check("t2_level_max", maxlvl, 4);

    // overflow, then full FIFO with pop and write together
    q.delete();
    expq.delete();
    maxlvl = 0;
    cap    = 1;
    for (int k = 0; k < 5; k++) expq.push_back(8'hA0 + 8'(k));
    for (int k = 0; k < 6; k++) begin
      wr_en   = 1'b1;
      wr_data = 8'hA0 + 8'(k);
      tick();
    end
    check("t3_level_full", level, 4);
    check("t3_ready_low", wr_ready, 0);
    wr_data = 8'hEE;
    e = 5;
    while (level == 3'd4 && e < 200) begin
      tick();
      e++;
    end
    wr_en = 1'b0;
    check("t4_pop_edge", e, 41);
    check("t4_level", level, 3);
    drain();
    cap = 0;
    decode("t3");
    check("t3_level_max", maxlvl, 4);

    // reset during data bit 3 of 0x3C with two bytes queued
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    tick();
    wr_en = 1'b0;
    check("t5_queued", level, 2);
    repeat (16) tick();
    check("t5_bit3", tx, 1);
    tick();
    check("t5_bit3b", tx, 1);
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    rst_n = 1'b1;
    wr_en = 1'b0;
    check("t5_tx", tx, 1);
    check("t5_level", level, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", wr_ready, 1);
    zeros = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx == 1'b0 || busy == 1'b1) zeros++;
    end
    check("t5_quiet", zeros, 0);
    check("t5_level_end", level, 0);

    // one clock per bit: 0xFF then 0x00 back-to-back
    pat      = 20'b0111111111_0000000001;
    wr_en1   = 1'b1;
    wr_data1 = 8'hFF;
    tick();
    wr_data1 = 8'h00;
    tick();
    wr_en1 = 1'b0;
    check("t6_pre_tx", tx1, 1);
    for (int j = 0; j < 20; j++) begin
      tick();
      check("t6_bit", tx1, pat[19-j]);
    end
    tick();
    check("t6_tx_idle", tx1, 1);
    check("t6_level", level1, 0);
    tick();
    check("t6_busy", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
